// File: rtl/dmem_wait.sv
// -----------------------------------------------------------------------------
// dmem_wait
//
// Word-addressed data memory for the pipelined core's Memory stage. Every
// access takes a programmable number of wait states. While the access is in
// progress the memory asserts 'stall' so the hazard unit holds the pipeline.
// The memory pulses 'done' in the cycle the result is available.
//
// Parameters
//   DEPTH : number of 32-bit words (power of two, >= 4)
//   WAIT  : wait states per access (0..15)
//
// Ports
//   clk   in   1  : clock, rising edge
//   reset in   1  : synchronous, active-high
//   re    in   1  : load request
//   we    in   1  : store request (wins over re when both are high)
//   a     in  32  : byte address; a[1:0] ignored, upper bits wrap
//   wd    in  32  : store data
//   rd    out 32  : load data, registered; holds the last loaded word
//   stall out  1  : hold Memory stage and everything upstream
//   done  out  1  : one-cycle pulse when an access completes
// -----------------------------------------------------------------------------
module dmem_wait #(
   parameter int DEPTH = 64,
   parameter int WAIT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        re,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        stall,
   output logic        done
);

   localparam int ADDR_W = $clog2(DEPTH);
   // Counter preload. A zero-wait memory never enters the wait state, so
   // the preload is only meaningful when WAIT > 0.
   localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state_reg, state_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic [ADDR_W-1:0] idx_reg, idx_next;
   logic [31:0]       wd_reg, wd_next;
   logic              store_reg, store_next;
   logic              load_reg, load_next;
   logic [31:0]       rd_reg;

   logic [31:0]       mem [DEPTH];

   logic              req;
   logic [ADDR_W-1:0] acc_idx;
   logic [31:0]       acc_wd;
   logic              acc_store;
   logic              acc_load;
   logic              enter_resp;
   logic              mem_we;
   logic              mem_re;

   // Byte-lane bits and address bits above the array are intentionally dropped.
   logic              unused_addr_bits;
   assign unused_addr_bits = ^{a[31:ADDR_W+2], a[1:0]};

   assign req = re | we;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         wd_reg    <= '0;
         store_reg <= 1'b0;
         load_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         wd_reg    <= wd_next;
         store_reg <= store_next;
         load_reg  <= load_next;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      wd_next    = wd_reg;
      store_next = store_reg;
      load_next  = load_reg;
      case (state_reg)
         S_IDLE: begin
            if (req) begin
               idx_next   = a[ADDR_W+1:2];
               wd_next    = wd;
               store_next = we;
               load_next  = re & ~we;
               if (WAIT > 0) begin
                  state_next = S_WAIT;
                  cnt_next   = CNT_INIT;
               end else begin
                  state_next = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (cnt_reg == 4'd0) begin
               state_next = S_RESP;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         S_RESP: begin
            // The core still holds its request this cycle; do not re-accept it.
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      stall = 1'b0;
      done  = 1'b0;
      case (state_reg)
         S_IDLE:  stall = req;
         S_WAIT:  stall = 1'b1;
         S_RESP:  done  = 1'b1;
         default: begin
            stall = 1'b0;
            done  = 1'b0;
         end
      endcase
   end

   // The array is touched on the edge that enters RESP. With WAIT = 0 that
   // edge is the one leaving IDLE, where the latches are only being loaded.
   // In that case the access must take the live inputs instead.
   always_comb begin
      if (state_reg == S_IDLE) begin
         acc_idx   = a[ADDR_W+1:2];
         acc_wd    = wd;
         acc_store = we;
         acc_load  = re & ~we;
      end else begin
         acc_idx   = idx_reg;
         acc_wd    = wd_reg;
         acc_store = store_reg;
         acc_load  = load_reg;
      end
   end

   // Reset aborts an in-flight access, so it also blocks the write.
   assign enter_resp = (state_next == S_RESP) && (state_reg != S_RESP) && !reset;
   assign mem_we     = enter_resp & acc_store;
   assign mem_re     = enter_resp & acc_load;

   // ------------------------------------------------------------ memory array
   // The array has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[acc_idx] <= acc_wd;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_reg <= '0;
      end else if (mem_re) begin
         rd_reg <= mem[acc_idx];
      end
   end

   assign rd = rd_reg;

endmodule
